// File: rtl/irq_dispatch.sv
// Interrupt dispatcher: registers the priority-encoder output and turns it into an
// ack/eoi handshaked request with preemption, timeout drop and a saturating service count.
module irq_dispatch #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CW      = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [2:0]    code_in,
  input  logic          idle_in,
  input  logic          ack,
  input  logic          eoi,
  output logic          irq,
  output logic [2:0]    vector,
  output logic          busy,
  output logic          timeout,
  output logic [CW-1:0] srv_count
);

  localparam int unsigned TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_SERV = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nx;
  logic [2:0]      code_r;
  logic            idle_r;
  logic [TW-1:0]   timer;
  logic [TW-1:0]   timer_nx;
  logic [2:0]      vector_nx;
  logic            timeout_nx;
  logic [CW-1:0]   srv_count_nx;

  // Input stage: the encoder is combinational, so the FSM only sees registered values
  always_ff @(posedge clk) begin
    if (rst) begin
      code_r <= 3'd0;
      idle_r <= 1'b1;
    end else begin
      code_r <= code_in;
      idle_r <= idle_in;
    end
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      irq       <= 1'b0;
      busy      <= 1'b0;
      timeout   <= 1'b0;
      vector    <= 3'd0;
      timer     <= '0;
      srv_count <= '0;
    end else begin
      state     <= state_nx;
      irq       <= (state_nx == ST_REQ);
      busy      <= (state_nx == ST_SERV);
      timeout   <= timeout_nx;
      vector    <= vector_nx;
      timer     <= timer_nx;
      srv_count <= srv_count_nx;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_nx     = state;
    vector_nx    = vector;
    timer_nx     = timer;
    timeout_nx   = 1'b0;
    srv_count_nx = srv_count;
    case (state)
      ST_IDLE: begin
        if (!idle_r) begin
          vector_nx = code_r;
          timer_nx  = '0;
          state_nx  = ST_REQ;
        end
      end
      ST_REQ: begin
        // ack outranks both preemption and expiry
        if (ack) begin
          state_nx = ST_SERV;
          if (srv_count != {CW{1'b1}}) begin
            srv_count_nx = srv_count + CW'(1);
          end
        end else if (!idle_r && (code_r > vector)) begin
          vector_nx = code_r;
          timer_nx  = '0;
        end else if (timer == TW'(TIMEOUT - 1)) begin
          timeout_nx = 1'b1;
          state_nx   = ST_IDLE;
        end else begin
          timer_nx = timer + TW'(1);
        end
      end
      ST_SERV: begin
        if (eoi) begin
          state_nx = ST_IDLE;
        end
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_irq_dispatch.sv
// Directed and random checks of irq_dispatch (CW=8 and CW=2 instances driven in parallel)
// against a behavioural request/service model.
module tb_irq_dispatch;

  localparam int unsigned TIMEOUT = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] code_in = 3'd0;
  logic       idle_in = 1'b1;
  logic       ack = 1'b0;
  logic       eoi = 1'b0;

  logic       irq8, busy8, to8, irq2, busy2, to2;
  logic [2:0] vec8, vec2;
  logic [7:0] cnt8;
  logic [1:0] cnt2;

  irq_dispatch #(.TIMEOUT(TIMEOUT), .CW(8)) u_dut8 (
    .clk(clk), .rst(rst), .code_in(code_in), .idle_in(idle_in), .ack(ack), .eoi(eoi),
    .irq(irq8), .vector(vec8), .busy(busy8), .timeout(to8), .srv_count(cnt8)
  );

  irq_dispatch #(.TIMEOUT(TIMEOUT), .CW(2)) u_dut2 (
    .clk(clk), .rst(rst), .code_in(code_in), .idle_in(idle_in), .ack(ack), .eoi(eoi),
    .irq(irq2), .vector(vec2), .busy(busy2), .timeout(to2), .srv_count(cnt2)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: a request is either pending, being serviced, or absent
  bit m_pending, m_serving, m_to, m_idle_q;
  int m_vec, m_age, m_cnt8, m_cnt2, m_code_q;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    if (rst) begin
      m_pending = 0; m_serving = 0; m_to = 0; m_vec = 0; m_age = 0;
      m_cnt8 = 0; m_cnt2 = 0; m_code_q = 0; m_idle_q = 1;
      return;
    end
    m_to = 0;
    if (m_serving) begin
      if (eoi) m_serving = 0;
    end else if (m_pending) begin
      if (ack) begin
        m_pending = 0;
        m_serving = 1;
        if (m_cnt8 < 255) m_cnt8++;
        if (m_cnt2 < 3) m_cnt2++;
      end else if (!m_idle_q && m_code_q > m_vec) begin
        m_vec = m_code_q;
        m_age = 0;
      end else if (m_age == TIMEOUT - 1) begin
        m_to = 1;
        m_pending = 0;
      end else begin
        m_age++;
      end
    end else if (!m_idle_q) begin
      m_pending = 1;
      m_vec = m_code_q;
      m_age = 0;
    end
    m_code_q = int'(code_in);
    m_idle_q = idle_in;
  endtask

  task automatic check_all();
    chk("irq8", 32'(irq8), 32'(m_pending));
    chk("busy8", 32'(busy8), 32'(m_serving));
    chk("vector8", 32'(vec8), 32'(m_vec));
    chk("timeout8", 32'(to8), 32'(m_to));
    chk("count8", 32'(cnt8), 32'(m_cnt8));
    chk("irq2", 32'(irq2), 32'(m_pending));
    chk("busy2", 32'(busy2), 32'(m_serving));
    chk("vector2", 32'(vec2), 32'(m_vec));
    chk("count2", 32'(cnt2), 32'(m_cnt2));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic serve_one(input logic [2:0] c);
    code_in = c; idle_in = 1'b0;
    step(); step();
    idle_in = 1'b1;
    ack = 1'b1; step(); ack = 1'b0;
    eoi = 1'b1; step(); eoi = 1'b0;
    step();
  endtask

  int pulses;

  initial begin
    // 1. Reset held with an active encoder input
    rst = 1'b1; code_in = 3'd5; idle_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_irq", 32'(irq8), 32'd0);
      chk("rst_vec", 32'(vec8), 32'd0);
    end
    idle_in = 1'b1; step();
    rst = 1'b0;

    // 2. Basic handshake, two-edge latency
    code_in = 3'd3; idle_in = 1'b0;
    step();
    chk("lat_irq_early", 32'(irq8), 32'd0);
    step();
    chk("lat_irq", 32'(irq8), 32'd1);
    chk("lat_vec", 32'(vec8), 32'd3);
    idle_in = 1'b1;
    ack = 1'b1; step(); ack = 1'b0;
    chk("hs_busy", 32'(busy8), 32'd1);
    chk("hs_cnt", 32'(cnt8), 32'd1);
    code_in = 3'd7; idle_in = 1'b0; step(); step();
    chk("serv_frozen", 32'(vec8), 32'd3);
    idle_in = 1'b1;
    eoi = 1'b1; step(); eoi = 1'b0;
    chk("eoi_busy", 32'(busy8), 32'd0);
    step(); step();

    // 3. Preemption by higher code, lower code ignored
    code_in = 3'd2; idle_in = 1'b0; step(); step();
    chk("pre_vec2", 32'(vec8), 32'd2);
    code_in = 3'd6; step(); step();
    chk("pre_vec6", 32'(vec8), 32'd6);
    code_in = 3'd1; step(); step(); step();
    chk("pre_hold6", 32'(vec8), 32'd6);
    idle_in = 1'b1;
    ack = 1'b1; step(); ack = 1'b0;
    eoi = 1'b1; step(); eoi = 1'b0;
    step(); step();

    // 4a. Timeout with no ack: exactly one pulse
    code_in = 3'd4; idle_in = 1'b0; step(); step();
    idle_in = 1'b1;
    pulses = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (to8) begin
        pulses++;
        chk("to_cycle", 32'(i), 32'd16);
      end
    end
    chk("to_pulses", 32'(pulses), 32'd1);
    chk("to_irq", 32'(irq8), 32'd0);

    // 4b. ack on the expiry cycle wins
    code_in = 3'd4; idle_in = 1'b0; step(); step();
    idle_in = 1'b1;
    for (int i = 0; i < 15; i++) step();
    ack = 1'b1; step(); ack = 1'b0;
    chk("exp_ack_busy", 32'(busy8), 32'd1);
    chk("exp_ack_to", 32'(to8), 32'd0);
    eoi = 1'b1; step(); eoi = 1'b0;
    step();

    // 5. Idle encoder with stray ack/eoi
    idle_in = 1'b1;
    for (int i = 0; i < 50; i++) begin
      ack = (i % 7 == 0); eoi = (i % 5 == 0); code_in = 3'(i);
      step();
    end
    ack = 1'b0; eoi = 1'b0;
    chk("idle_irq", 32'(irq8), 32'd0);

    // 6. Saturation and reset mid-service
    rst = 1'b1; step(); rst = 1'b0;
    for (int i = 0; i < 5; i++) serve_one(3'(i));
    chk("sat_cnt2", 32'(cnt2), 32'd3);
    chk("sat_cnt8", 32'(cnt8), 32'd5);
    code_in = 3'd7; idle_in = 1'b0; step(); step();
    idle_in = 1'b1; ack = 1'b1; step(); ack = 1'b0;
    chk("mid_busy", 32'(busy8), 32'd1);
    rst = 1'b1; step(); rst = 1'b0;
    chk("mid_rst_busy", 32'(busy8), 32'd0);
    chk("mid_rst_vec", 32'(vec8), 32'd0);
    chk("mid_rst_cnt", 32'(cnt8), 32'd0);

    // Random phase
    for (int i = 0; i < 600; i++) begin
      rst     = ($urandom_range(63) == 0);
      code_in = 3'($urandom_range(7));
      idle_in = ($urandom_range(1) == 1);
      ack     = ($urandom_range(5) == 0);
      eoi     = ($urandom_range(3) == 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
